// File: rtl/threshold_counter_pkg.sv
// Shared types, default parameters and helpers for the threshold reset counter.
package threshold_counter_pkg;

  typedef enum logic {RUN, HOLD} trc_state_t;

  localparam int unsigned DEF_WIDTH       = 4;
  localparam int unsigned DEF_THRESHOLD   = 8;
  localparam int unsigned DEF_RESET_DELAY = 2;

  // Bits needed to hold a recovery timer value in 0..delay.
  function automatic int unsigned timer_width(input int unsigned delay);
    return $clog2(delay + 1);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that flags the cycle it holds the value one.
module hold_timer #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             is_one
);

  logic [WIDTH-1:0] value_q;

  // Load has priority over decrement; the counter saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= load_val;
    end else if (dec && (value_q != '0)) begin
      value_q <= value_q - WIDTH'(1);
    end
  end

  assign is_one = (value_q == WIDTH'(1));

endmodule

// File: rtl/threshold_reset_counter.sv
// Enable-driven up-counter that freezes once it exceeds a programmable threshold and
// clears itself a fixed number of cycles later.
module threshold_reset_counter
  import threshold_counter_pkg::*;
#(
  parameter int unsigned WIDTH             = DEF_WIDTH,
  parameter int unsigned DEFAULT_THRESHOLD = DEF_THRESHOLD,
  parameter int unsigned RESET_DELAY       = DEF_RESET_DELAY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  input  logic             thr_load,
  input  logic [WIDTH-1:0] thr_value,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] threshold,
  output logic             over,
  output logic             recovering,
  output logic             clr_done,
  output logic             wrapped,
  output logic             thr_pending
);

  localparam int unsigned    TW     = timer_width(RESET_DELAY);
  localparam logic [TW-1:0]  TLOAD  = TW'(RESET_DELAY - 1);
  // With a one-cycle delay the overflow edge is itself the clearing edge.
  localparam bit             SINGLE = (RESET_DELAY == 1);

  trc_state_t       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] thr_q, thr_d;
  logic [WIDTH-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             clr_done_q, clr_done_d;
  logic             wrapped_q, wrapped_d;
  logic             tmr_load, tmr_dec, tmr_is_one;

  assign over = (count_q > thr_q);

  hold_timer #(
    .WIDTH (TW)
  ) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (TLOAD),
    .dec      (tmr_dec),
    .is_one   (tmr_is_one)
  );

  // Next-state: counting, recovery entry/exit and threshold load/deferral.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    thr_d      = thr_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    clr_done_d = 1'b0;
    wrapped_d  = 1'b0;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    case (state_q)
      RUN: begin
        if (over) begin
          if (SINGLE) begin
            count_d    = '0;
            clr_done_d = 1'b1;
            if (thr_load) thr_d = thr_value;
          end else begin
            state_d  = HOLD;
            tmr_load = 1'b1;
            // A load on the entry edge waits for the clearing edge.
            if (thr_load) begin
              pend_d     = 1'b1;
              pend_val_d = thr_value;
            end
          end
        end else begin
          if (thr_load) thr_d = thr_value;
          if (inc_en) begin
            count_d   = count_q + WIDTH'(1);
            wrapped_d = (count_q == '1);
          end
        end
      end
      HOLD: begin
        if (tmr_is_one) begin
          count_d    = '0;
          state_d    = RUN;
          clr_done_d = 1'b1;
          pend_d     = 1'b0;
          // A load arriving on the clearing edge is the newest, so it wins.
          if (thr_load)    thr_d = thr_value;
          else if (pend_q) thr_d = pend_val_q;
        end else begin
          tmr_dec = 1'b1;
          if (thr_load) begin
            pend_d     = 1'b1;
            pend_val_d = thr_value;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      count_q    <= '0;
      thr_q      <= WIDTH'(DEFAULT_THRESHOLD);
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      clr_done_q <= 1'b0;
      wrapped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      thr_q      <= thr_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      clr_done_q <= clr_done_d;
      wrapped_q  <= wrapped_d;
    end
  end

  assign count       = count_q;
  assign threshold   = thr_q;
  assign recovering  = (state_q == HOLD);
  assign clr_done    = clr_done_q;
  assign wrapped     = wrapped_q;
  assign thr_pending = pend_q;

endmodule

// File: tb/tb_threshold_reset_counter.sv
// Directed bench for threshold_reset_counter: default build plus delay-1 and delay-4 builds.
module tb_threshold_reset_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inc_en = 1'b0;
  logic       thr_load = 1'b0;
  logic [3:0] thr_value = 4'd0;

  logic [3:0] count, threshold;
  logic       over, recovering, clr_done, wrapped, thr_pending;
  logic [3:0] count1, threshold1;
  logic       over1, recovering1, clr_done1, wrapped1, thr_pending1;
  logic [3:0] count4, threshold4;
  logic       over4, recovering4, clr_done4, wrapped4, thr_pending4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  threshold_reset_counter dut (
    .clk(clk), .rst(rst), .inc_en(inc_en), .thr_load(thr_load), .thr_value(thr_value),
    .count(count), .threshold(threshold), .over(over), .recovering(recovering),
    .clr_done(clr_done), .wrapped(wrapped), .thr_pending(thr_pending)
  );

  threshold_reset_counter #(.RESET_DELAY(1)) dut1 (
    .clk(clk), .rst(rst), .inc_en(inc_en), .thr_load(thr_load), .thr_value(thr_value),
    .count(count1), .threshold(threshold1), .over(over1), .recovering(recovering1),
    .clr_done(clr_done1), .wrapped(wrapped1), .thr_pending(thr_pending1)
  );

  threshold_reset_counter #(.RESET_DELAY(4)) dut4 (
    .clk(clk), .rst(rst), .inc_en(inc_en), .thr_load(thr_load), .thr_value(thr_value),
    .count(count4), .threshold(threshold4), .over(over4), .recovering(recovering4),
    .clr_done(clr_done4), .wrapped(wrapped4), .thr_pending(thr_pending4)
  );

  // Recovery property on the delay-2 build, keyed on the first over-threshold sample.
  logic       prev_over;
  logic [1:0] chk_pipe;
  always @(posedge clk) begin
    if (rst) begin
      chk_pipe  <= 2'b00;
      prev_over <= 1'b0;
    end else begin
      if (chk_pipe[1] === 1'b1) begin
        n_cmp = n_cmp + 1;
        if (count !== 4'd0) begin
          n_err = n_err + 1;
          $display("FAIL prop_delay2: count=%0d want 0", count);
        end
      end
      chk_pipe  <= {chk_pipe[0], over && !prev_over};
      prev_over <= over;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; inc_en = 1'b0; thr_load = 1'b0; thr_value = 4'd0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 7;
    if (count !== 4'd0)       begin n_err++; $display("FAIL rst_count: got %0d want 0", count); end
    if (threshold !== 4'd8)   begin n_err++; $display("FAIL rst_thr: got %0d want 8", threshold); end
    if (over !== 1'b0)        begin n_err++; $display("FAIL rst_over: got %b want 0", over); end
    if (recovering !== 1'b0)  begin n_err++; $display("FAIL rst_rec: got %b want 0", recovering); end
    if (clr_done !== 1'b0)    begin n_err++; $display("FAIL rst_clr: got %b want 0", clr_done); end
    if (wrapped !== 1'b0)     begin n_err++; $display("FAIL rst_wrap: got %b want 0", wrapped); end
    if (thr_pending !== 1'b0) begin n_err++; $display("FAIL rst_pend: got %b want 0", thr_pending); end
  endtask

  task automatic test_count_recover();
    int pulses;
    do_reset();
    inc_en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      n_cmp++;
      if (count !== 4'(k)) begin n_err++; $display("FAIL run_count: got %0d want %0d", count, k); end
    end
    n_cmp += 2;
    if (over !== 1'b1)       begin n_err++; $display("FAIL run_over: got %b want 1", over); end
    if (recovering !== 1'b0) begin n_err++; $display("FAIL run_rec0: got %b want 0", recovering); end
    step();
    n_cmp += 2;
    if (count !== 4'd9)      begin n_err++; $display("FAIL hold_count: got %0d want 9", count); end
    if (recovering !== 1'b1) begin n_err++; $display("FAIL hold_rec: got %b want 1", recovering); end
    step();
    n_cmp += 3;
    if (count !== 4'd0)      begin n_err++; $display("FAIL clr_count: got %0d want 0", count); end
    if (clr_done !== 1'b1)   begin n_err++; $display("FAIL clr_pulse: got %b want 1", clr_done); end
    if (recovering !== 1'b0) begin n_err++; $display("FAIL clr_rec: got %b want 0", recovering); end
    pulses = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (clr_done === 1'b1) pulses++;
    end
    n_cmp += 2;
    if (pulses != 1)    begin n_err++; $display("FAIL clr_once: got %0d pulses want 1", pulses); end
    if (count !== 4'd3) begin n_err++; $display("FAIL post_clr_count: got %0d want 3", count); end
    inc_en = 1'b0;
  endtask

  task automatic test_thr_load_run();
    do_reset();
    inc_en = 1'b1;
    repeat (5) step();
    inc_en = 1'b0;
    thr_load = 1'b1; thr_value = 4'd3;
    n_cmp++;
    if (over !== 1'b0) begin n_err++; $display("FAIL ld_over_before: got %b want 0", over); end
    step();
    thr_load = 1'b0;
    n_cmp += 3;
    if (threshold !== 4'd3) begin n_err++; $display("FAIL ld_thr: got %0d want 3", threshold); end
    if (over !== 1'b1)      begin n_err++; $display("FAIL ld_over: got %b want 1", over); end
    if (count !== 4'd5)     begin n_err++; $display("FAIL ld_count: got %0d want 5", count); end
    step();
    n_cmp += 2;
    if (count !== 4'd5)      begin n_err++; $display("FAIL ld_hold: got %0d want 5", count); end
    if (recovering !== 1'b1) begin n_err++; $display("FAIL ld_rec: got %b want 1", recovering); end
    step();
    n_cmp += 2;
    if (count !== 4'd0)    begin n_err++; $display("FAIL ld_clr: got %0d want 0", count); end
    if (clr_done !== 1'b1) begin n_err++; $display("FAIL ld_clr_done: got %b want 1", clr_done); end
  endtask

  task automatic test_thr_load_hold();
    do_reset();
    inc_en = 1'b1;
    repeat (9) step();
    thr_load = 1'b1; thr_value = 4'd12;
    step();
    thr_load = 1'b0;
    n_cmp += 3;
    if (thr_pending !== 1'b1) begin n_err++; $display("FAIL def_pend: got %b want 1", thr_pending); end
    if (threshold !== 4'd8)   begin n_err++; $display("FAIL def_thr_old: got %0d want 8", threshold); end
    if (recovering !== 1'b1)  begin n_err++; $display("FAIL def_rec: got %b want 1", recovering); end
    step();
    n_cmp += 3;
    if (count !== 4'd0)       begin n_err++; $display("FAIL def_clr: got %0d want 0", count); end
    if (threshold !== 4'd12)  begin n_err++; $display("FAIL def_thr_new: got %0d want 12", threshold); end
    if (thr_pending !== 1'b0) begin n_err++; $display("FAIL def_pend_clr: got %b want 0", thr_pending); end
    repeat (12) step();
    n_cmp += 2;
    if (count !== 4'd12) begin n_err++; $display("FAIL def_cnt12: got %0d want 12", count); end
    if (over !== 1'b0)   begin n_err++; $display("FAIL def_over12: got %b want 0", over); end
    step();
    n_cmp += 2;
    if (count !== 4'd13) begin n_err++; $display("FAIL def_cnt13: got %0d want 13", count); end
    if (over !== 1'b1)   begin n_err++; $display("FAIL def_over13: got %b want 1", over); end
    inc_en = 1'b0;
    step(); step();
  endtask

  task automatic test_wrap();
    int ov;
    int wr;
    do_reset();
    thr_load = 1'b1; thr_value = 4'd15;
    step();
    thr_load = 1'b0;
    n_cmp++;
    if (threshold !== 4'd15) begin n_err++; $display("FAIL wrap_thr: got %0d want 15", threshold); end
    inc_en = 1'b1;
    ov = 0; wr = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (over === 1'b1) ov++;
      if (wrapped === 1'b1) wr++;
    end
    n_cmp += 2;
    if (count !== 4'd15) begin n_err++; $display("FAIL wrap_cnt15: got %0d want 15", count); end
    if (wr != 0)         begin n_err++; $display("FAIL wrap_early: got %0d pulses want 0", wr); end
    step();
    if (over === 1'b1) ov++;
    n_cmp += 2;
    if (count !== 4'd0)   begin n_err++; $display("FAIL wrap_cnt0: got %0d want 0", count); end
    if (wrapped !== 1'b1) begin n_err++; $display("FAIL wrap_pulse: got %b want 1", wrapped); end
    step();
    if (over === 1'b1) ov++;
    n_cmp += 3;
    if (count !== 4'd1)   begin n_err++; $display("FAIL wrap_cnt1: got %0d want 1", count); end
    if (wrapped !== 1'b0) begin n_err++; $display("FAIL wrap_one_shot: got %b want 0", wrapped); end
    if (ov != 0)          begin n_err++; $display("FAIL wrap_over: got %0d over samples want 0", ov); end
    inc_en = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    inc_en = 1'b1;
    repeat (9) step();
    thr_load = 1'b1; thr_value = 4'd4;
    step();
    thr_load = 1'b0;
    n_cmp += 2;
    if (recovering !== 1'b1)  begin n_err++; $display("FAIL mid_rec: got %b want 1", recovering); end
    if (thr_pending !== 1'b1) begin n_err++; $display("FAIL mid_pend: got %b want 1", thr_pending); end
    rst = 1'b1; inc_en = 1'b0;
    step();
    rst = 1'b0;
    n_cmp += 7;
    if (count !== 4'd0)       begin n_err++; $display("FAIL mid_count: got %0d want 0", count); end
    if (threshold !== 4'd8)   begin n_err++; $display("FAIL mid_thr: got %0d want 8", threshold); end
    if (over !== 1'b0)        begin n_err++; $display("FAIL mid_over: got %b want 0", over); end
    if (recovering !== 1'b0)  begin n_err++; $display("FAIL mid_rec_rst: got %b want 0", recovering); end
    if (clr_done !== 1'b0)    begin n_err++; $display("FAIL mid_clr: got %b want 0", clr_done); end
    if (wrapped !== 1'b0)     begin n_err++; $display("FAIL mid_wrap: got %b want 0", wrapped); end
    if (thr_pending !== 1'b0) begin n_err++; $display("FAIL mid_pend_rst: got %b want 0", thr_pending); end
    step();
    n_cmp += 2;
    if (clr_done !== 1'b0)  begin n_err++; $display("FAIL mid_clr_after: got %b want 0", clr_done); end
    if (threshold !== 4'd8) begin n_err++; $display("FAIL mid_thr_after: got %0d want 8", threshold); end
  endtask

  task automatic test_delay_variants();
    do_reset();
    inc_en = 1'b1;
    repeat (9) step();
    n_cmp += 2;
    if (over1 !== 1'b1) begin n_err++; $display("FAIL d1_over: got %b want 1", over1); end
    if (over4 !== 1'b1) begin n_err++; $display("FAIL d4_over: got %b want 1", over4); end
    step();
    n_cmp += 4;
    if (count1 !== 4'd0)      begin n_err++; $display("FAIL d1_clr: got %0d want 0", count1); end
    if (clr_done1 !== 1'b1)   begin n_err++; $display("FAIL d1_clr_done: got %b want 1", clr_done1); end
    if (recovering1 !== 1'b0) begin n_err++; $display("FAIL d1_rec: got %b want 0", recovering1); end
    if (count4 !== 4'd9)      begin n_err++; $display("FAIL d4_hold1: got %0d want 9", count4); end
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp += 2;
      if (count4 !== 4'd9)      begin n_err++; $display("FAIL d4_hold: got %0d want 9", count4); end
      if (recovering4 !== 1'b1) begin n_err++; $display("FAIL d4_rec: got %b want 1", recovering4); end
    end
    step();
    n_cmp += 3;
    if (count4 !== 4'd0)      begin n_err++; $display("FAIL d4_clr: got %0d want 0", count4); end
    if (clr_done4 !== 1'b1)   begin n_err++; $display("FAIL d4_clr_done: got %b want 1", clr_done4); end
    if (recovering4 !== 1'b0) begin n_err++; $display("FAIL d4_rec_end: got %b want 0", recovering4); end
    inc_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_recover();
    test_thr_load_run();
    test_thr_load_hold();
    test_wrap();
    test_reset_mid_hold();
    test_delay_variants();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
